// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg -- shared encodings and limits for the stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_e;

  // Highest value each BCD field may hold before it rolls over.
  localparam logic [7:0] CS_MAX  = 8'h99;
  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;

  // 50 MHz / 100 Hz.
  localparam int TICK_DIV_DEFAULT = 500000;

endpackage

// File: rtl/bcd_time_counter.sv
// bcd_time_counter -- mm:ss.cc BCD cascade with saturation at 59:59.99.
// Exposes both the registered time and its next value so the parent can
// register a display that tracks the time with no extra lag.
module bcd_time_counter
  import stopwatch_pkg::*;
(
  input  logic       clk_50MHz,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [7:0] cs_bcd,
  output logic [7:0] min_nxt,
  output logic [7:0] sec_nxt,
  output logic [7:0] cs_nxt,
  output logic       sat
);

  logic [7:0] min_q, sec_q, cs_q;

  // Two-digit BCD increment that wraps to 00 once the field limit is reached.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim)         return 8'h00;
    if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // All three fields at their limit: another count would have to wrap the clock.
  function automatic logic at_ceiling(input logic [7:0] m, input logic [7:0] s,
                                      input logic [7:0] c);
    return (m == MIN_MAX) && (s == SEC_MAX) && (c == CS_MAX);
  endfunction

  assign sat     = at_ceiling(min_q, sec_q, cs_q);
  assign min_bcd = min_q;
  assign sec_bcd = sec_q;
  assign cs_bcd  = cs_q;

  // Next-value cascade: cs carries into sec, sec into min; hold when saturated.
  always_comb begin
    min_nxt = min_q;
    sec_nxt = sec_q;
    cs_nxt  = cs_q;
    if (clr) begin
      min_nxt = 8'h00;
      sec_nxt = 8'h00;
      cs_nxt  = 8'h00;
    end else if (inc && !sat) begin
      cs_nxt = bcd_inc(cs_q, CS_MAX);
      if (cs_q == CS_MAX) begin
        sec_nxt = bcd_inc(sec_q, SEC_MAX);
        if (sec_q == SEC_MAX) min_nxt = bcd_inc(min_q, MIN_MAX);
      end
    end
  end

  // Time registers.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      min_q <= 8'h00;
      sec_q <= 8'h00;
      cs_q  <= 8'h00;
    end else begin
      min_q <= min_nxt;
      sec_q <= sec_nxt;
      cs_q  <= cs_nxt;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl -- centisecond stopwatch: 100 Hz prescaler, IDLE/RUN/PAUSE
// control, BCD time counter and registered display mux.
// Optional lap-freeze feature: define STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int CNT_W    = 19
) (
  input  logic       clk_50MHz,
  input  logic       rst,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  output logic [7:0] disp_min_bcd,
  output logic [7:0] disp_sec_bcd,
  output logic [7:0] disp_cs_bcd,
  output logic       tick_100Hz,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  sw_state_e        state, state_nxt;
  logic [CNT_W-1:0] presc;
  logic             tick, sat, clear_go, ovf_q;
  logic [7:0]       min_live, sec_live, cs_live;
  logic [7:0]       min_nxt, sec_nxt, cs_nxt;
  logic             lap_q, lap_act_nxt;
  logic [7:0]       lap_min_nxt, lap_sec_nxt, lap_cs_nxt;
  logic [7:0]       disp_min_q, disp_sec_q, disp_cs_q;

  // Tick only while running; clear is honoured only from PAUSE.
  assign tick     = (state == RUN) && (presc == TICK_LAST);
  assign clear_go = (state == PAUSE) && btn_clear;

  // Prescaler: counts in RUN, freezes in PAUSE, zero in IDLE so a fresh start
  // yields its first tick exactly TICK_DIV cycles after the press.
  always_ff @(posedge clk_50MHz) begin
    if (rst || clear_go || state == IDLE) begin
      presc <= '0;
    end else if (state == RUN) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_50MHz) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: a saturating tick forces PAUSE; clear beats start_stop in PAUSE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (btn_start_stop) state_nxt = RUN;
      RUN:     if ((tick && sat) || btn_start_stop) state_nxt = PAUSE;
      PAUSE: begin
        if (btn_clear)                      state_nxt = IDLE;
        else if (btn_start_stop && !ovf_q)  state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sticky overflow, dropped only by clear or reset.
  always_ff @(posedge clk_50MHz) begin
    if (rst || clear_go)  ovf_q <= 1'b0;
    else if (tick && sat) ovf_q <= 1'b1;
  end

  bcd_time_counter u_time (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .clr       (clear_go),
    .inc       (tick),
    .min_bcd   (min_live),
    .sec_bcd   (sec_live),
    .cs_bcd    (cs_live),
    .min_nxt   (min_nxt),
    .sec_nxt   (sec_nxt),
    .cs_nxt    (cs_nxt),
    .sat       (sat)
  );

`ifdef STOPWATCH_LAP_EN
  logic [7:0] lap_min_q, lap_sec_q, lap_cs_q;

  // Lap toggle: capture the pre-increment live time in RUN, release in RUN/PAUSE.
  always_comb begin
    lap_act_nxt = lap_q;
    lap_min_nxt = lap_min_q;
    lap_sec_nxt = lap_sec_q;
    lap_cs_nxt  = lap_cs_q;
    if (clear_go) begin
      lap_act_nxt = 1'b0;
      lap_min_nxt = 8'h00;
      lap_sec_nxt = 8'h00;
      lap_cs_nxt  = 8'h00;
    end else if (btn_lap) begin
      if (lap_q && state != IDLE) begin
        lap_act_nxt = 1'b0;
      end else if (!lap_q && state == RUN) begin
        lap_act_nxt = 1'b1;
        lap_min_nxt = min_live;
        lap_sec_nxt = sec_live;
        lap_cs_nxt  = cs_live;
      end
    end
  end

  // Lap register and flag.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      lap_q     <= 1'b0;
      lap_min_q <= 8'h00;
      lap_sec_q <= 8'h00;
      lap_cs_q  <= 8'h00;
    end else begin
      lap_q     <= lap_act_nxt;
      lap_min_q <= lap_min_nxt;
      lap_sec_q <= lap_sec_nxt;
      lap_cs_q  <= lap_cs_nxt;
    end
  end
`else
  logic unused_btn_lap;
  assign unused_btn_lap = btn_lap;
  assign lap_q          = 1'b0;
  assign lap_act_nxt    = 1'b0;
  assign lap_min_nxt    = 8'h00;
  assign lap_sec_nxt    = 8'h00;
  assign lap_cs_nxt     = 8'h00;
`endif

  // Registered display mux fed from next values so it tracks time without lag.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      disp_min_q <= 8'h00;
      disp_sec_q <= 8'h00;
      disp_cs_q  <= 8'h00;
    end else if (lap_act_nxt) begin
      disp_min_q <= lap_min_nxt;
      disp_sec_q <= lap_sec_nxt;
      disp_cs_q  <= lap_cs_nxt;
    end else begin
      disp_min_q <= min_nxt;
      disp_sec_q <= sec_nxt;
      disp_cs_q  <= cs_nxt;
    end
  end

  assign disp_min_bcd = disp_min_q;
  assign disp_sec_bcd = disp_sec_q;
  assign disp_cs_bcd  = disp_cs_q;
  assign tick_100Hz   = tick;
  assign running      = (state == RUN);
  assign lap_active   = lap_q;
  assign overflow     = ovf_q;

endmodule
